// File: rtl/pixel_pkg.sv
// Shared types for the pixel readout path: FSM states, the tagged sample record
// and the integer square root used to size row/column addresses.
package pixel_pkg;

  localparam int PIX_DATA_W = 8;
  localparam int PIX_ADDR_W = 1;

  typedef enum logic [1:0] {IDLE, CONV, READ, DONE} readout_state_e;

  typedef struct packed {
    logic [PIX_DATA_W-1:0] data;
    logic [PIX_ADDR_W-1:0] row;
    logic [PIX_ADDR_W-1:0] col;
    logic                  sof;
    logic                  eof;
  } pix_sample_t;

  function automatic int isqrt(input int n);
    int r;
    r = 0;
    for (int i = 0; i <= n; i++) begin
      if (i * i <= n) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; a push on a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module pixel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pixel_readout.sv
// Single-slope ADC ramp generator plus per-frame pixel capture into an output
// FIFO, tagging each sample with its address and frame start/end markers.
module pixel_readout
  import pixel_pkg::*;
#(
  parameter int NUM_PIXELS = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_W    = $clog2(isqrt(NUM_PIXELS))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              convert_i,
  input  logic              read_i,
  input  logic [ADDR_W-1:0] row_addr_i,
  input  logic [ADDR_W-1:0] col_addr_i,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic [DATA_W-1:0] ramp_o,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_row,
  output logic [ADDR_W-1:0] out_col,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow_o,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(NUM_PIXELS + 1);
  localparam int SMP_W = DATA_W + 2 * ADDR_W + 2;
  localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_PIXELS - 1);

  function automatic logic [DATA_W-1:0] ramp_sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  readout_state_e    state_q, state_d;
  logic [DATA_W-1:0] ramp_q;
  logic [CNT_W-1:0]  count_q, count_d, count_eff;
  logic              overflow_q;
  logic              capture, push_req, pop, fifo_full, fifo_empty;
  logic              head_sof, head_eof;
  logic [SMP_W-1:0]  smp_in, smp_out;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (read_i)         state_d = READ;
        else if (convert_i) state_d = CONV;
      end
      CONV:    if (read_i)  state_d = READ;
      READ:    if (!read_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The cycle that enters READ already captures, using a freshly cleared count.
  always_comb begin
    capture   = read_i && (state_d == READ);
    count_eff = (state_q == READ) ? count_q : '0;
    push_req  = capture && (count_eff < NUM_C);
    count_d   = count_q;
    if (capture) count_d = push_req ? count_eff + 1'b1 : count_eff;
    smp_in    = {pix_data_i, row_addr_i, col_addr_i,
                 (count_eff == '0), (count_eff == LAST_C)};
  end

  assign pop = !fifo_empty && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ramp_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ramp_q  <= convert_i ? ramp_sat_inc(ramp_q) : '0;
      count_q <= count_d;
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  pixel_sync_fifo #(
    .WIDTH (SMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .wdata_i (smp_in),
    .pop_i   (pop),
    .rdata_o (smp_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {out_data, out_row, out_col, head_sof, head_eof} = smp_out;
  assign out_sof    = head_sof && !fifo_empty;
  assign out_eof    = head_eof && !fifo_empty;
  assign out_valid  = !fifo_empty;
  assign ramp_o     = ramp_q;
  assign overflow_o = overflow_q;
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout with a queue-based reference model checked every cycle.
module tb_pixel_readout;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          convert_i = 1'b0;
  logic          read_i = 1'b0;
  logic [0:0]    row_addr_i = '0;
  logic [0:0]    col_addr_i = '0;
  logic [DW-1:0] pix_data_i = '0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] ramp_o, out_data;
  logic [0:0]    out_row, out_col;
  logic          out_sof, out_eof, out_valid, overflow_o, frame_done;

  pixel_readout #(.NUM_PIXELS(NP), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .convert_i(convert_i), .read_i(read_i),
    .row_addr_i(row_addr_i), .col_addr_i(col_addr_i), .pix_data_i(pix_data_i),
    .ramp_o(ramp_o), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_sof(out_sof), .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready),
    .overflow_o(overflow_o), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are read bursts; the k-th high cycle of a burst
  // carries pixel k, and only the first NP of them are kept.
  typedef struct {int data; int row; int col; int sof; int eof;} smp_t;
  smp_t m_q[$];
  int   m_ramp = 0, m_ovf = 0, m_fd = 0, m_in_read = 0, m_burst = 0;
  bit   m_init = 0;
  int   log_d[$], log_s[$], log_e[$];
  int   fd_cnt = 0;

  always @(posedge clk) begin
    smp_t s;
    bit   have, pop;
    if (reset) begin
      m_q.delete();
      m_ramp = 0; m_ovf = 0; m_fd = 0; m_in_read = 0; m_burst = 0;
      m_init = 1;
    end else if (m_init) begin
      if (out_valid && out_ready) begin
        log_d.push_back(int'(out_data));
        log_s.push_back(int'(out_sof));
        log_e.push_back(int'(out_eof));
      end
      have = 0;
      pop  = (m_q.size() > 0) && out_ready;
      if (read_i) begin
        if (m_burst < NP) begin
          s.data = int'(pix_data_i); s.row = int'(row_addr_i); s.col = int'(col_addr_i);
          s.sof = (m_burst == 0); s.eof = (m_burst == NP - 1);
          have = 1;
        end
        m_burst++;
      end else begin
        m_burst = 0;
      end
      m_fd      = (m_in_read != 0 && !read_i) ? 1 : 0;
      m_in_read = read_i ? 1 : 0;
      if (pop) void'(m_q.pop_front());
      if (have) begin
        if (m_q.size() < DEPTH) m_q.push_back(s);
        else m_ovf = 1;
      end
      m_ramp = convert_i ? ((m_ramp >= 255) ? 255 : m_ramp + 1) : 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("valid", int'(out_valid), int'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("data", int'(out_data), m_q[0].data);
        check("row",  int'(out_row),  m_q[0].row);
        check("col",  int'(out_col),  m_q[0].col);
        check("sof",  int'(out_sof),  m_q[0].sof);
        check("eof",  int'(out_eof),  m_q[0].eof);
      end
      check("ramp",       int'(ramp_o),     m_ramp);
      check("overflow",   int'(overflow_o), m_ovf);
      check("frame_done", int'(frame_done), m_fd);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic run_frame(input int rdy_from);
    for (int i = 0; i < 5; i++) begin
      read_i     = 1'b1;
      row_addr_i = 1'((i % 4) / 2);
      col_addr_i = 1'(i % 2);
      pix_data_i = 8'(10 * (i + 1));
      out_ready  = (i >= rdy_from);
      @(negedge clk);
    end
    read_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_log();
    log_d.delete(); log_s.delete(); log_e.delete();
  endtask

  int exp4[4] = '{10, 20, 30, 40};

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ramp", int'(ramp_o), 0);
    check("rst_ovf", int'(overflow_o), 0);
    check("rst_fd", int'(frame_done), 0);
    reset = 1'b0;

    // Ramp saturation
    convert_i = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2 || k == 255 || k == 256 || k == 300)
        check("ramp_lit", int'(ramp_o), (k > 255) ? 255 : k);
    end
    convert_i = 1'b0;
    @(negedge clk);
    check("ramp_zero", int'(ramp_o), 0);

    // Normal frame after convert
    clear_log(); fd_cnt = 0;
    run_frame(0);
    check("f1_beats", log_d.size(), 4);
    for (int i = 0; i < 4 && i < log_d.size(); i++) check("f1_data", log_d[i], exp4[i]);
    if (log_d.size() == 4) begin
      check("f1_sof0", log_s[0], 1);
      check("f1_eof3", log_e[3], 1);
      check("f1_eof0", log_e[0], 0);
    end
    check("f1_fd_pulses", fd_cnt, 1);

    // Overflow with sink stalled
    clear_log();
    run_frame(99);
    check("ov_sticky", int'(overflow_o), 1);
    check("ov_head", int'(out_data), 10);
    check("ov_nobeats", log_d.size(), 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ov_drain", log_d.size(), 2);
    if (log_d.size() == 2) check("ov_second", log_d[1], 20);
    run_frame(0);
    check("ov_next_frame", int'(overflow_o), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("ov_cleared", int'(overflow_o), 0);

    // Full FIFO with simultaneous pop on a capture cycle
    clear_log();
    run_frame(2);
    check("fp_ovf", int'(overflow_o), 0);
    check("fp_beats", log_d.size(), 4);
    for (int i = 0; i < 4 && i < log_d.size(); i++) check("fp_order", log_d[i], exp4[i]);

    // Reset in the middle of a read phase
    out_ready = 1'b0; convert_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      read_i = 1'b1; row_addr_i = 1'((i % 4) / 2); col_addr_i = 1'(i % 2);
      pix_data_i = 8'(10 * (i + 1));
      @(negedge clk);
    end
    check("mr_valid_before", int'(out_valid), 1);
    reset = 1'b1; read_i = 1'b0;
    @(negedge clk);
    check("mr_valid", int'(out_valid), 0);
    check("mr_ramp", int'(ramp_o), 0);
    check("mr_ovf", int'(overflow_o), 0);
    check("mr_fd", int'(frame_done), 0);
    reset = 1'b0; convert_i = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
    run_frame(0);
    check("mr_beats", log_d.size(), 4);
    if (log_d.size() == 4) begin
      check("mr_sof", log_s[0], 1);
      check("mr_first", log_d[0], 10);
    end

    // Two back-to-back frames without convert
    clear_log(); fd_cnt = 0;
    run_frame(0);
    run_frame(0);
    check("bb_beats", log_d.size(), 8);
    begin
      int ns, ne;
      ns = 0; ne = 0;
      foreach (log_s[i]) ns += log_s[i];
      foreach (log_e[i]) ne += log_e[i];
      check("bb_sof", ns, 2);
      check("bb_eof", ne, 2);
    end
    if (log_d.size() == 8) check("bb_fifth", log_d[4], 10);
    check("bb_fd", fd_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
